// File: rtl/event_pkg.sv
// Shared constants for the event-report sink: header value, event codes and strobe bit positions.
// Used by event_decoder (optional timestamp capture is enabled with EVENT_TIMESTAMP_EN).
package event_pkg;

   localparam int EVENT_TYPES = 3;

   localparam logic [7:0] EVT_HEADER         = 8'h01;
   localparam logic [7:0] EVT_CODE_UNDERFLOW = 8'd1;
   localparam logic [7:0] EVT_CODE_EVENT_A   = 8'd2;
   localparam logic [7:0] EVT_CODE_EVENT_B   = 8'd3;

   localparam int EVT_BIT_UNDERFLOW = int'(EVT_CODE_UNDERFLOW) - 1;
   localparam int EVT_BIT_EVENT_A   = int'(EVT_CODE_EVENT_A) - 1;
   localparam int EVT_BIT_EVENT_B   = int'(EVT_CODE_EVENT_B) - 1;

   function automatic logic beat_is_good(input logic [7:0] hdr, input logic [7:0] code,
                                         input int n_types);
      return (hdr == EVT_HEADER) && (code != 8'd0) && (int'(code) <= n_types);
   endfunction

endpackage

// File: rtl/event_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes effect before the same-cycle increment.
module event_sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;
   logic [W-1:0] base;

   always_comb begin
      base  = clr ? '0 : cnt_q;
      cnt_d = base;
      if (inc && (base != '1)) begin
         cnt_d = base + W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/event_decoder.sv
// AXI-Stream event-report sink: stages each beat, decodes it into strobes, sticky flags and counters.
// Define EVENT_TIMESTAMP_EN to capture a per-event timestamp into last_ts; otherwise last_ts is 0.
module event_decoder #(
   parameter int EVENT_TYPES = event_pkg::EVENT_TYPES,
   parameter int COUNT_WIDTH = 32,
   parameter int TS_WIDTH    = 32
) (
   input  logic                               clk,
   input  logic                               resetn,
   input  logic [255:0]                       AXIS_IN_TDATA,
   input  logic                               AXIS_IN_TVALID,
   output logic                               AXIS_IN_TREADY,
   input  logic                               pause,
   input  logic                               clear_counts,
   output logic [EVENT_TYPES-1:0]             evt_strobe,
   output logic [EVENT_TYPES-1:0]             evt_seen,
   output logic [EVENT_TYPES*COUNT_WIDTH-1:0] event_count,
   output logic [COUNT_WIDTH-1:0]             bad_count,
   output logic                               bad_seen,
   output logic [EVENT_TYPES*TS_WIDTH-1:0]    last_ts
);
   import event_pkg::*;

   logic                   tready_q, tready_d;
   logic                   stg_valid_q, stg_valid_d;
   logic [7:0]             stg_code_q, stg_code_d;
   logic [7:0]             stg_hdr_q, stg_hdr_d;
   logic [EVENT_TYPES-1:0] strobe_q, strobe_d;
   logic [EVENT_TYPES-1:0] seen_q, seen_d;
   logic                   bad_seen_q, bad_seen_d;

   logic                   handshake;
   logic                   good;
   logic                   bad;
   logic [EVENT_TYPES-1:0] hit;
   logic [EVENT_TYPES:0]   inc_vec;
   logic [COUNT_WIDTH-1:0] cnt_arr [EVENT_TYPES+1];

   // Only the code and header bytes carry meaning.
   logic unused_tdata;
   assign unused_tdata = ^AXIS_IN_TDATA[247:8];

   assign handshake = AXIS_IN_TVALID & tready_q;

   always_comb begin
      tready_d    = ~pause;
      stg_valid_d = handshake;
      stg_code_d  = stg_code_q;
      stg_hdr_d   = stg_hdr_q;
      if (handshake) begin
         stg_code_d = AXIS_IN_TDATA[7:0];
         stg_hdr_d  = AXIS_IN_TDATA[255:248];
      end

      good = stg_valid_q && beat_is_good(stg_hdr_q, stg_code_q, EVENT_TYPES);
      bad  = stg_valid_q && !good;
      hit  = '0;
      for (int k = 0; k < EVENT_TYPES; k++) begin
         hit[k] = good && (stg_code_q == 8'(k + 1));
      end

      strobe_d   = hit;
      seen_d     = (clear_counts ? '0 : seen_q) | hit;
      bad_seen_d = (clear_counts ? 1'b0 : bad_seen_q) | bad;
      inc_vec    = {bad, hit};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tready_q    <= 1'b0;
         stg_valid_q <= 1'b0;
         stg_code_q  <= '0;
         stg_hdr_q   <= '0;
         strobe_q    <= '0;
         seen_q      <= '0;
         bad_seen_q  <= 1'b0;
      end else begin
         tready_q    <= tready_d;
         stg_valid_q <= stg_valid_d;
         stg_code_q  <= stg_code_d;
         stg_hdr_q   <= stg_hdr_d;
         strobe_q    <= strobe_d;
         seen_q      <= seen_d;
         bad_seen_q  <= bad_seen_d;
      end
   end

   // Slot EVENT_TYPES is the malformed-beat counter; the rest follow event code order.
   generate
      for (genvar gi = 0; gi <= EVENT_TYPES; gi++) begin : g_cnt
         event_sat_counter #(.W(COUNT_WIDTH)) u_cnt (
            .clk    (clk),
            .resetn (resetn),
            .clr    (clear_counts),
            .inc    (inc_vec[gi]),
            .cnt    (cnt_arr[gi])
         );
      end
      for (genvar gi = 0; gi < EVENT_TYPES; gi++) begin : g_cnt_out
         assign event_count[gi*COUNT_WIDTH +: COUNT_WIDTH] = cnt_arr[gi];
      end
   endgenerate

   assign bad_count      = cnt_arr[EVENT_TYPES];
   assign AXIS_IN_TREADY = tready_q;
   assign evt_strobe     = strobe_q;
   assign evt_seen       = seen_q;
   assign bad_seen       = bad_seen_q;

`ifdef EVENT_TIMESTAMP_EN
   logic [TS_WIDTH-1:0]             ts_q, ts_d;
   logic [TS_WIDTH-1:0]             stg_ts_q, stg_ts_d;
   logic [EVENT_TYPES*TS_WIDTH-1:0] last_ts_q, last_ts_d;

   // The stage copy pins each event to its handshake cycle rather than its decode cycle.
   always_comb begin
      ts_d      = ts_q + TS_WIDTH'(1);
      stg_ts_d  = handshake ? ts_q : stg_ts_q;
      last_ts_d = clear_counts ? '0 : last_ts_q;
      for (int k = 0; k < EVENT_TYPES; k++) begin
         if (hit[k]) begin
            last_ts_d[k*TS_WIDTH +: TS_WIDTH] = stg_ts_q;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         ts_q      <= '0;
         stg_ts_q  <= '0;
         last_ts_q <= '0;
      end else begin
         ts_q      <= ts_d;
         stg_ts_q  <= stg_ts_d;
         last_ts_q <= last_ts_d;
      end
   end

   assign last_ts = last_ts_q;
`else
   assign last_ts = '0;
`endif

endmodule

// File: tb/tb_event_decoder.sv
// Self-checking bench for event_decoder: directed sequences, a vector table and randomized traffic
// checked every cycle against a queue-based reference model.
module tb_event_decoder;

   localparam int ET = 3;
   localparam int CW = 4;
   localparam int TW = 32;

   logic                clk;
   logic                resetn;
   logic [255:0]        AXIS_IN_TDATA;
   logic                AXIS_IN_TVALID;
   logic                AXIS_IN_TREADY;
   logic                pause;
   logic                clear_counts;
   logic [ET-1:0]       evt_strobe;
   logic [ET-1:0]       evt_seen;
   logic [ET*CW-1:0]    event_count;
   logic [CW-1:0]       bad_count;
   logic                bad_seen;
   logic [ET*TW-1:0]    last_ts;

   event_decoder #(.EVENT_TYPES(ET), .COUNT_WIDTH(CW), .TS_WIDTH(TW)) dut (
      .clk            (clk),
      .resetn         (resetn),
      .AXIS_IN_TDATA  (AXIS_IN_TDATA),
      .AXIS_IN_TVALID (AXIS_IN_TVALID),
      .AXIS_IN_TREADY (AXIS_IN_TREADY),
      .pause          (pause),
      .clear_counts   (clear_counts),
      .evt_strobe     (evt_strobe),
      .evt_seen       (evt_seen),
      .event_count    (event_count),
      .bad_count      (bad_count),
      .bad_seen       (bad_seen),
      .last_ts        (last_ts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 0;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic logic [CW-1:0] cnt_of(input int k);
      return event_count[k*CW +: CW];
   endfunction

   function automatic logic [TW-1:0] ts_of(input int k);
      return last_ts[k*TW +: TW];
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic [7:0]    hdr;
      logic [7:0]    code;
      logic [TW-1:0] ts;
   } beat_t;

   beat_t         inflight[$];
   logic [CW-1:0] m_cnt [ET];
   logic [TW-1:0] m_last [ET];
   logic [CW-1:0] m_bad;
   logic [ET-1:0] m_seen;
   logic [ET-1:0] m_strobe;
   logic          m_bad_seen;
   logic          m_tready;
   logic [TW-1:0] m_ts;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == {CW{1'b1}}) ? v : CW'(v + 1);
   endfunction

   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int k = 0; k < ET; k++) begin
            m_cnt[k]  <= '0;
            m_last[k] <= '0;
         end
         m_bad      <= '0;
         m_seen     <= '0;
         m_strobe   <= '0;
         m_bad_seen <= 1'b0;
         m_tready   <= 1'b0;
         m_ts       <= '0;
         inflight.delete();
      end else begin
         beat_t         b;
         logic [CW-1:0] cnt_v [ET];
         logic [TW-1:0] lt_v [ET];
         logic [CW-1:0] bad_v;
         logic [ET-1:0] seen_v;
         logic [ET-1:0] stb;
         logic          bs_v;
         int            idx;
         stb    = '0;
         bad_v  = clear_counts ? '0 : m_bad;
         seen_v = clear_counts ? '0 : m_seen;
         bs_v   = clear_counts ? 1'b0 : m_bad_seen;
         for (int k = 0; k < ET; k++) begin
            cnt_v[k] = clear_counts ? '0 : m_cnt[k];
            lt_v[k]  = clear_counts ? '0 : m_last[k];
         end
         if (inflight.size() > 0) begin
            b = inflight.pop_front();
            if (b.hdr == 8'h01 && b.code >= 8'd1 && int'(b.code) <= ET) begin
               idx         = int'(b.code) - 1;
               stb[idx]    = 1'b1;
               seen_v[idx] = 1'b1;
               cnt_v[idx]  = sat_inc(cnt_v[idx]);
               lt_v[idx]   = b.ts;
            end else begin
               bad_v = sat_inc(bad_v);
               bs_v  = 1'b1;
            end
         end
         if (AXIS_IN_TVALID && m_tready) begin
            b.hdr  = AXIS_IN_TDATA[255:248];
            b.code = AXIS_IN_TDATA[7:0];
            b.ts   = m_ts;
            inflight.push_back(b);
         end
         for (int k = 0; k < ET; k++) begin
            m_cnt[k]  <= cnt_v[k];
            m_last[k] <= lt_v[k];
         end
         m_bad      <= bad_v;
         m_seen     <= seen_v;
         m_bad_seen <= bs_v;
         m_strobe   <= stb;
         m_ts       <= m_ts + 1;
         m_tready   <= !pause;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_tready", 64'(AXIS_IN_TREADY), 64'(m_tready));
         check("model_strobe", 64'(evt_strobe), 64'(m_strobe));
         check("model_seen", 64'(evt_seen), 64'(m_seen));
         check("model_bad_count", 64'(bad_count), 64'(m_bad));
         check("model_bad_seen", 64'(bad_seen), 64'(m_bad_seen));
         for (int k = 0; k < ET; k++) begin
            check($sformatf("model_count%0d", k), 64'(cnt_of(k)), 64'(m_cnt[k]));
`ifdef EVENT_TIMESTAMP_EN
            check($sformatf("model_last_ts%0d", k), 64'(ts_of(k)), 64'(m_last[k]));
`endif
         end
`ifndef EVENT_TIMESTAMP_EN
         check("model_last_ts_zero", 64'(|last_ts), 64'd0);
`endif
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [255:0] make_data(input logic [7:0] hdr, input logic [7:0] code);
      logic [255:0] d;
      d = {8{$urandom()}};
      d[255:248] = hdr;
      d[7:0]     = code;
      return d;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one beat and returns just after its handshake edge.
   task automatic send_beat(input logic [7:0] hdr, input logic [7:0] code, output logic [TW-1:0] hs_ts);
      int waited = 0;
      bit done = 0;
      hs_ts = '0;
      AXIS_IN_TDATA  = make_data(hdr, code);
      AXIS_IN_TVALID = 1'b1;
      while (!done && waited < 50) begin
         @(negedge clk);
         if (AXIS_IN_TREADY) begin
            hs_ts = m_ts;
            done  = 1;
         end
         tick();
         waited++;
      end
      AXIS_IN_TVALID = 1'b0;
      if (!done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL send_beat_timeout: got no handshake required handshake within 50 cycles");
      end
   endtask

   task automatic pulse_clear();
      clear_counts = 1'b1;
      tick();
      clear_counts = 1'b0;
   endtask

   typedef struct {
      logic [7:0]    hdr;
      logic [7:0]    code;
      logic [ET-1:0] exp_strobe;
      logic [CW-1:0] exp_bad;
   } vec_t;

   vec_t          vecs [8];
   logic [ET-1:0] got_stb [6];
   logic [ET-1:0] exp_b2b [4];
   logic [7:0]    codes_b2b [4];
   logic [TW-1:0] hs;
   bit            last_hs;

   initial begin
      vecs[0] = '{8'h02, 8'h01, 3'b000, 4'd1};
      vecs[1] = '{8'h01, 8'h00, 3'b000, 4'd2};
      vecs[2] = '{8'h01, 8'h04, 3'b000, 4'd3};
      vecs[3] = '{8'h01, 8'h01, 3'b001, 4'd3};
      vecs[4] = '{8'h01, 8'h03, 3'b100, 4'd3};
      vecs[5] = '{8'hFF, 8'h02, 3'b000, 4'd4};
      vecs[6] = '{8'h01, 8'hFF, 3'b000, 4'd5};
      vecs[7] = '{8'h01, 8'h02, 3'b010, 4'd5};
      codes_b2b = '{8'd1, 8'd3, 8'd3, 8'd2};
      exp_b2b   = '{3'b001, 3'b100, 3'b100, 3'b010};

      // Reset with a beat already waiting on the bus.
      resetn         = 1'b0;
      pause          = 1'b0;
      clear_counts   = 1'b0;
      AXIS_IN_TDATA  = make_data(8'h01, 8'h02);
      AXIS_IN_TVALID = 1'b1;
      #12;
      check("reset_tready", 64'(AXIS_IN_TREADY), 64'd0);
      check("reset_strobe", 64'(evt_strobe), 64'd0);
      check("reset_counts", 64'(event_count), 64'd0);
      check("reset_bad", 64'({bad_count, bad_seen, evt_seen}), 64'd0);
      check("reset_last_ts", 64'(|last_ts), 64'd0);
      chk_en = 1;
      #10 resetn = 1'b1;
      tick();
      check("t1_tready_after_reset", 64'(AXIS_IN_TREADY), 64'd1);
      tick();
      AXIS_IN_TVALID = 1'b0;
      tick();
      check("t1_strobe", 64'(evt_strobe), 64'b010);
      check("t1_count1", 64'(cnt_of(1)), 64'd1);
      check("t1_seen", 64'(evt_seen), 64'b010);
`ifdef EVENT_TIMESTAMP_EN
      check("t1_last_ts1", 64'(ts_of(1)), 64'd1);
`endif
      tick();
      check("t1_strobe_one_cycle", 64'(evt_strobe), 64'b000);

      // Back-to-back beats, one per cycle.
      pulse_clear();
      for (int j = 0; j < 6; j++) begin
         if (j < 4) begin
            AXIS_IN_TDATA  = make_data(8'h01, codes_b2b[j]);
            AXIS_IN_TVALID = 1'b1;
         end else begin
            AXIS_IN_TVALID = 1'b0;
         end
         tick();
         got_stb[j] = evt_strobe;
      end
      check("t2_strobe_first", 64'(got_stb[0]), 64'd0);
      for (int j = 0; j < 4; j++) begin
         check($sformatf("t2_strobe%0d", j), 64'(got_stb[j+1]), 64'(exp_b2b[j]));
      end
      check("t2_strobe_after", 64'(got_stb[5]), 64'd0);
      check("t2_count0", 64'(cnt_of(0)), 64'd1);
      check("t2_count1", 64'(cnt_of(1)), 64'd1);
      check("t2_count2", 64'(cnt_of(2)), 64'd2);
      check("t2_bad", 64'(bad_count), 64'd0);

      // Vector table: good and malformed beats.
      pulse_clear();
      for (int i = 0; i < 8; i++) begin
         send_beat(vecs[i].hdr, vecs[i].code, hs);
         tick();
         check($sformatf("vec%0d_strobe", i), 64'(evt_strobe), 64'(vecs[i].exp_strobe));
         check($sformatf("vec%0d_bad_count", i), 64'(bad_count), 64'(vecs[i].exp_bad));
      end
      check("vec_bad_seen", 64'(bad_seen), 64'd1);
      check("vec_seen", 64'(evt_seen), 64'b111);

      // Saturation of a 4-bit counter.
      pulse_clear();
      for (int i = 0; i < 17; i++) send_beat(8'h01, 8'h01, hs);
      tick();
      check("t4_saturate", 64'(cnt_of(0)), 64'hF);

      // Clear landing on the same edge as a decode.
      send_beat(8'h01, 8'h03, hs);
      clear_counts = 1'b1;
      tick();
      clear_counts = 1'b0;
      check("t5_count0", 64'(cnt_of(0)), 64'd0);
      check("t5_count1", 64'(cnt_of(1)), 64'd0);
      check("t5_count2", 64'(cnt_of(2)), 64'd1);
      check("t5_seen", 64'(evt_seen), 64'b100);
      check("t5_strobe", 64'(evt_strobe), 64'b100);
      check("t5_bad", 64'({bad_count, bad_seen}), 64'd0);

      // Pause with a beat waiting, then pause right after a handshake.
      pause = 1'b1;
      tick();
      check("t6_tready_low", 64'(AXIS_IN_TREADY), 64'd0);
      AXIS_IN_TDATA  = make_data(8'h01, 8'h01);
      AXIS_IN_TVALID = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_no_decode", 64'(evt_strobe), 64'd0);
      end
      pause = 1'b0;
      send_beat(8'h01, 8'h01, hs);
      tick();
      check("t6_held_strobe", 64'(evt_strobe), 64'b001);
`ifdef EVENT_TIMESTAMP_EN
      check("t6_last_ts0", 64'(ts_of(0)), 64'(hs));
`endif
      send_beat(8'h01, 8'h02, hs);
      pause = 1'b1;
      tick();
      check("t6_staged_strobe", 64'(evt_strobe), 64'b010);
      pause = 1'b0;
      tick();

      // Reset while a beat sits in the stage register.
      send_beat(8'h01, 8'h03, hs);
      resetn = 1'b0;
      #3;
      check("rst_mid_counts", 64'(event_count), 64'd0);
      @(negedge clk);
      #2 resetn = 1'b1;
      tick();
      check("rst_mid_strobe", 64'(evt_strobe), 64'd0);
      check("rst_mid_count2", 64'(cnt_of(2)), 64'd0);
      tick();

      // Randomized traffic against the model.
      last_hs = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!AXIS_IN_TVALID || last_hs) begin
            AXIS_IN_TVALID = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
               AXIS_IN_TDATA = make_data(8'h01, 8'($urandom_range(1, ET)));
            else
               AXIS_IN_TDATA = make_data(8'($urandom_range(0, 2)), 8'($urandom_range(0, 5)));
         end
         pause        = ($urandom_range(0, 7) == 0);
         clear_counts = ($urandom_range(0, 63) == 0);
         @(negedge clk);
         last_hs = AXIS_IN_TVALID && AXIS_IN_TREADY;
         tick();
      end
      AXIS_IN_TVALID = 1'b0;
      pause          = 1'b0;
      clear_counts   = 1'b0;
      repeat (4) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
